// File: rtl/dtree_pkg.sv
// dtree_pkg: shared types and default sizes for the decision-tree feature loader.
//   state_t    - loader FSM states (LOAD, DRAIN, SETTLE, HOLD)
//   N_FEAT     - default number of features per frame
//   FEAT_W     - default feature width
//   CLS_W      - default class width
//   feat_vec_t - one feature vector (N_FEAT entries of FEAT_W bits)
package dtree_pkg;

  localparam int N_FEAT = 4;
  localparam int FEAT_W = 8;
  localparam int CLS_W  = 2;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef logic [FEAT_W-1:0] feat_vec_t [N_FEAT];

endpackage

// File: rtl/dtree_feature_loader_vote3.sv
// dtree_vote3: combinational 3-input majority voter.
//   newest, middle, oldest - class samples, newest first
//   count                  - number of valid samples (1..3)
//   winner                 - majority class; the newest sample when fewer than
//                            three are valid or when all three differ
module dtree_vote3 #(
  parameter int CLS_W = dtree_pkg::CLS_W
) (
  input  logic [CLS_W-1:0] newest,
  input  logic [CLS_W-1:0] middle,
  input  logic [CLS_W-1:0] oldest,
  input  logic [1:0]       count,
  output logic [CLS_W-1:0] winner
);
  import dtree_pkg::*;

  // The only case where the newest sample loses is when the two older samples
  // agree with each other and not with it.
  always_comb begin
    winner = newest;
    if ((count == 2'd3) && (middle == oldest) && (newest != middle)) begin
      winner = middle;
    end
  end

endmodule

// File: rtl/dtree_feature_loader.sv
// dtree_feature_loader: assembles a byte-stream frame into a feature vector,
// holds it on the tree inputs for SETTLE_CYCLES, then samples the tree class
// and offers it on a valid/ready result handshake.
//   clk, rst                       - clock, asynchronous active-high reset
//   in_valid/in_data/in_last/in_ready - feature byte stream, feature 0 first
//   x0..x3                         - committed feature vector to the tree
//   cls_in                         - tree class output
//   res_valid/res_class/res_ready  - result handshake
//   frame_err                      - one-cycle pulse on a malformed frame
// Build option: define DTREE_VOTE_EN to report the majority of the last three
// sampled classes instead of the raw sample.
//
// state  | meaning
// LOAD   | accepting frame bytes into staging
// DRAIN  | discarding bytes of an overlong frame until in_last
// SETTLE | vector committed, waiting for the tree to settle
// HOLD   | result valid, waiting for res_ready
module dtree_feature_loader #(
  parameter int N_FEAT        = dtree_pkg::N_FEAT,
  parameter int FEAT_W        = dtree_pkg::FEAT_W,
  parameter int CLS_W         = dtree_pkg::CLS_W,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [FEAT_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [FEAT_W-1:0] x0,
  output logic [FEAT_W-1:0] x1,
  output logic [FEAT_W-1:0] x2,
  output logic [FEAT_W-1:0] x3,
  input  logic [CLS_W-1:0]  cls_in,
  output logic              res_valid,
  output logic [CLS_W-1:0]  res_class,
  input  logic              res_ready,
  output logic              frame_err
);
  import dtree_pkg::*;

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int CNT_W = 8;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [FEAT_W-1:0] staging_q [N_FEAT-1];
  logic [FEAT_W-1:0] x_q [N_FEAT];
  logic [CLS_W-1:0]  class_d;

  logic last_idx;
  logic settle_done;
  logic load_acc;
  logic commit;
  logic err;
  logic sample;

  assign last_idx    = (idx_q == IDX_W'(N_FEAT - 1));
  assign settle_done = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

  // The output ports are fixed at four features.
  assign x0 = x_q[0];
  assign x1 = x_q[1];
  assign x2 = x_q[2];
  assign x3 = x_q[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: begin
        if (in_valid && last_idx) begin
          state_d = in_last ? SETTLE : DRAIN;
        end
      end
      DRAIN: begin
        if (in_valid && in_last) begin
          state_d = LOAD;
        end
      end
      SETTLE: begin
        if (settle_done) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // in_ready depends on the state register only, so in_valid never reaches it.
  always_comb begin
    in_ready = 1'b0;
    load_acc = 1'b0;
    commit   = 1'b0;
    err      = 1'b0;
    sample   = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        load_acc = in_valid;
        commit   = in_valid && last_idx && in_last;
        err      = in_valid && (last_idx != in_last);
      end
      DRAIN: begin
        in_ready = 1'b1;
      end
      SETTLE: begin
        sample = settle_done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      cnt_q     <= '0;
      res_valid <= 1'b0;
      res_class <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < N_FEAT - 1; i++) staging_q[i] <= '0;
      for (int i = 0; i < N_FEAT; i++) x_q[i] <= '0;
    end else begin
      frame_err <= err;

      if (load_acc) begin
        for (int i = 0; i < N_FEAT - 1; i++) begin
          if (idx_q == IDX_W'(i)) staging_q[i] <= in_data;
        end
        // Any frame end (good or early) and an overlong frame both restart at 0;
        // DRAIN leaves the index untouched.
        idx_q <= (in_last || last_idx) ? '0 : idx_q + 1'b1;
      end

      if (commit) begin
        for (int i = 0; i < N_FEAT - 1; i++) x_q[i] <= staging_q[i];
        x_q[N_FEAT-1] <= in_data;
        cnt_q         <= '0;
      end else if ((state_q == SETTLE) && !settle_done) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (sample) begin
        res_valid <= 1'b1;
        res_class <= class_d;
      end else if ((state_q == HOLD) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef DTREE_VOTE_EN
  // The two previous samples; together with cls_in they form the 3-deep window.
  logic [CLS_W-1:0] hist_q [2];
  logic [1:0]       hist_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q[0]  <= '0;
      hist_q[1]  <= '0;
      hist_cnt_q <= 2'd0;
    end else if (sample) begin
      hist_q[0] <= cls_in;
      hist_q[1] <= hist_q[0];
      if (hist_cnt_q != 2'd2) hist_cnt_q <= hist_cnt_q + 2'd1;
    end
  end

  dtree_vote3 #(
    .CLS_W (CLS_W)
  ) u_vote (
    .newest (cls_in),
    .middle (hist_q[0]),
    .oldest (hist_q[1]),
    .count  (hist_cnt_q + 2'd1),
    .winner (class_d)
  );
`else
  assign class_d = cls_in;
`endif

endmodule

// File: tb/tb_dtree_feature_loader.sv
module tb_dtree_feature_loader;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [7:0] x0, x1, x2, x3;
  logic [1:0] cls_in;
  logic       res_valid;
  logic [1:0] res_class;
  logic       res_ready;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_x [4];
  logic [1:0] hist [$];

  always #5 clk = ~clk;

  // Small generated-style decision tree driven by the loader's feature vector.
  function automatic logic [1:0] tree_model(input logic [7:0] a, b, c, d);
    if (a < 8'd100) return (b < 8'd30) ? 2'd2 : 2'd0;
    else            return (d > 8'd150) ? 2'd1 : 2'd3;
  endfunction

  assign cls_in = tree_model(x0, x1, x2, x3);

  dtree_feature_loader #(
    .N_FEAT        (4),
    .FEAT_W        (8),
    .CLS_W         (2),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .cls_in    (cls_in),
    .res_valid (res_valid),
    .res_class (res_class),
    .res_ready (res_ready),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] exp_vec();
    return {exp_x[0], exp_x[1], exp_x[2], exp_x[3]};
  endfunction

  // Reported class from the sampled one: raw, or majority over the last three.
  function automatic logic [1:0] expected_class(input logic [1:0] c);
    hist.push_front(c);
    if (hist.size() > 3) void'(hist.pop_back());
`ifdef DTREE_VOTE_EN
    if (hist.size() == 3) begin
      if (hist[0] == hist[1] || hist[0] == hist[2]) return hist[0];
      if (hist[1] == hist[2]) return hist[1];
    end
    return hist[0];
`else
    return c;
`endif
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic last, input logic exp_err, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
      step();
      check("frame_err_idle", {31'd0, frame_err}, 32'd0);
    end
    check("in_ready_rx", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
  endtask

  function automatic int rgap();
    return ($urandom_range(0, 3) == 0) ? 1 : 0;
  endfunction

  task automatic good_frame(input logic [7:0] fr [4], input logic rr_early, input int hold);
    logic [1:0] exp_c;
    int k;
    bit seen;
    bit stable;
    for (int i = 0; i < 4; i++) send_byte(fr[i], (i == 3), 1'b0, rgap());
    for (int i = 0; i < 4; i++) exp_x[i] = fr[i];
    exp_c = expected_class(tree_model(fr[0], fr[1], fr[2], fr[3]));
    check("x_commit", {x0, x1, x2, x3}, exp_vec());
    check("in_ready_settle", {31'd0, in_ready}, 32'd0);
    res_ready = rr_early;
    k = 0;
    seen = 0;
    stable = 1;
    while (!seen && k < S + 4) begin
      step();
      k++;
      if (res_valid) seen = 1;
      else if (in_ready !== 1'b0 || {x0, x1, x2, x3} !== exp_vec()) stable = 0;
    end
    check("settle_stable", {31'd0, stable}, 32'd1);
    check("settle_latency", k, S);
    if (seen) begin
      check("res_class", {30'd0, res_class}, {30'd0, exp_c});
      if (!rr_early) begin
        for (int h = 0; h < hold; h++) begin
          step();
          check("hold_valid", {29'd0, res_valid, in_ready, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
          check("hold_class", {30'd0, res_class}, {30'd0, exp_c});
        end
        check("hold_x", {x0, x1, x2, x3}, exp_vec());
        res_ready = 1'b1;
      end
      step();
      res_ready = 1'b0;
      check("res_valid_clear", {31'd0, res_valid}, 32'd0);
      check("in_ready_after", {31'd0, in_ready}, 32'd1);
    end
    res_ready = 1'b0;
  endtask

  task automatic early_last(input logic [7:0] fr [4], input int n);
    for (int i = 0; i < n; i++) send_byte(fr[i], (i == n - 1), (i == n - 1), rgap());
    check("x_early_keep", {x0, x1, x2, x3}, exp_vec());
  endtask

  task automatic missing_last(input logic [7:0] fr [4], input int extra);
    for (int i = 0; i < 4; i++) send_byte(fr[i], 1'b0, (i == 3), rgap());
    for (int j = 0; j < extra; j++) send_byte(8'($urandom), 1'b0, 1'b0, rgap());
    send_byte(8'($urandom), 1'b1, 1'b0, rgap());
    check("x_drain_keep", {x0, x1, x2, x3}, exp_vec());
  endtask

  task automatic reset_in_settle(input logic [7:0] fr [4], input int at);
    bit any_valid;
    for (int i = 0; i < 4; i++) send_byte(fr[i], (i == 3), 1'b0, rgap());
    for (int i = 0; i < at; i++) step();
    #2 rst = 1'b1;
    #1;
    check("rst_async_out", {28'd0, res_valid, in_ready, frame_err, 1'b0}, {28'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    check("rst_async_x", {x0, x1, x2, x3}, 32'd0);
    for (int i = 0; i < 4; i++) exp_x[i] = 8'd0;
    hist.delete();
    step();
    rst = 1'b0;
    any_valid = 0;
    for (int i = 0; i < S + 2; i++) begin
      step();
      if (res_valid !== 1'b0) any_valid = 1;
    end
    check("rst_no_result", {31'd0, any_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int kind;
    logic [7:0] fr [4];

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_last   = 1'b0;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_x[i] = 8'd0;
    repeat (3) step();
    check("reset_out", {28'd0, in_ready, res_valid, frame_err, 1'b0}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("reset_x", {x0, x1, x2, x3}, 32'd0);
    check("reset_class", {30'd0, res_class}, 32'd0);
    rst = 1'b0;
    step();

    good_frame('{8'd50, 8'd20, 8'd10, 8'd10}, 1'b1, 0);
    check("nominal_x", {x0, x1, x2, x3}, {8'd50, 8'd20, 8'd10, 8'd10});
    good_frame('{8'd200, 8'd200, 8'd200, 8'd200}, 1'b0, 10);
    early_last('{8'd1, 8'd2, 8'd3, 8'd4}, 2);
    good_frame('{8'd10, 8'd90, 8'd77, 8'd5}, 1'b0, 2);
    missing_last('{8'd9, 8'd8, 8'd7, 8'd6}, 1);
    good_frame('{8'd150, 8'd3, 8'd4, 8'd20}, 1'b1, 0);
    reset_in_settle('{8'd60, 8'd61, 8'd62, 8'd63}, 2);
    good_frame('{8'd120, 8'd0, 8'd0, 8'd255}, 1'b0, 1);

    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 99);
      for (int i = 0; i < 4; i++) fr[i] = 8'($urandom);
      if (kind < 60)      good_frame(fr, 1'($urandom), $urandom_range(0, 6));
      else if (kind < 78) early_last(fr, $urandom_range(1, 3));
      else if (kind < 93) missing_last(fr, $urandom_range(0, 3));
      else                reset_in_settle(fr, $urandom_range(0, S - 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
